// File: rtl/mmio_pkg.sv
// Register map and bit positions shared by the MMIO transmit port.
// Latency: n/a (constants only).
// Backpressure: n/a.
package mmio_pkg;

    localparam logic [31:0] DEFAULT_BASE = 32'h0000_1000;

    // Byte offsets of the three registers inside the window
    localparam logic [31:0] OFF_DATA   = 32'd0;
    localparam logic [31:0] OFF_STATUS = 32'd4;
    localparam logic [31:0] OFF_CTRL   = 32'd8;

    // STATUS bit positions
    localparam int ST_EMPTY   = 0;
    localparam int ST_FULL    = 1;
    localparam int ST_OVF     = 2;
    localparam int ST_CNT_LSB = 8;

    // CTRL bit positions
    localparam int CTRL_EN     = 0;
    localparam int CTRL_CLR    = 1;
    localparam int CTRL_OVFCLR = 2;

endpackage

// File: rtl/mmio_tx_port_if.sv
// Core data-bus side and byte-stream side of the MMIO transmit port.
// Latency: n/a (signal bundle).
// Backpressure: TxValid/TxReady handshake on the stream side.
interface mmio_tx_port_if;
    logic        MemWrite;
    logic [31:0] Addr;
    logic [31:0] WriteData;
    logic        Hit;
    logic [31:0] RdData;
    logic [7:0]  TxData;
    logic        TxValid;
    logic        TxReady;

    // master: core plus downstream consumer; slave: the port itself
    modport master (
        output MemWrite, Addr, WriteData, TxReady,
        input  Hit, RdData, TxData, TxValid
    );
    modport slave (
        input  MemWrite, Addr, WriteData, TxReady,
        output Hit, RdData, TxData, TxValid
    );
endinterface

// File: rtl/fifo_sync.sv
// Synchronous FIFO with clear; a push into a full FIFO is taken when a pop happens the same cycle.
// Latency: 1 cycle from push to dout/empty update.
// Backpressure: caller sees full; pushes refused while full unless paired with a pop; clr dominates.
module fifo_sync #(
    parameter int W     = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             clr,
    input  logic [W-1:0]     din,
    output logic [W-1:0]     dout,
    output logic             empty,
    output logic             full,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [AW:0]   cnt;
    logic          do_push, do_pop;

    assign empty   = (cnt == '0);
    assign full    = (cnt == FULL_CNT);
    assign count   = cnt;
    assign dout    = mem[rptr];
    assign do_pop  = pop & ~empty;
    // A full FIFO can still take a byte when the head leaves on the same edge
    assign do_push = push & (~full | do_pop);

    // Storage write; cleared on reset so the head byte reads 0 afterwards
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (do_push && !clr) begin
            mem[wptr] <= din;
        end
    end

    // Pointer and occupancy tracking; clr empties and discards any same-cycle push/pop
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else if (clr) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (do_push) wptr <= wptr + PTR_ONE;
            if (do_pop)  rptr <= rptr + PTR_ONE;
            if (do_push && !do_pop)      cnt <= cnt + CNT_ONE;
            else if (do_pop && !do_push) cnt <= cnt - CNT_ONE;
        end
    end
endmodule

// File: rtl/mmio_tx_port.sv
// Memory-mapped byte transmit port: DATA/STATUS/CTRL window, FIFO-buffered stores drained to a consumer.
// Latency: store at edge k visible on TxData/TxValid and STATUS in cycle k+1; reads are combinational.
// Backpressure: TxReady low holds TxData; stores into a full FIFO are dropped and flagged in sticky ovf.
module mmio_tx_port
    import mmio_pkg::*;
#(
    parameter int          DEPTH = 16,
    parameter logic [31:0] BASE  = DEFAULT_BASE
) (
    input  logic          clk,
    input  logic          rst,
    mmio_tx_port_if.slave bus
);
    localparam int AW = $clog2(DEPTH);

    logic [31:0] off;
    logic        hit, wr, push, ctrl_wr, clr, ovfclr, pop, drop;
    logic        en, ovf, empty, full, tx_vld;
    logic [7:0]  head;
    logic [AW:0] cnt;
    logic [31:0] cnt_ext;
    logic [31:0] rd;
    logic        unused_bits;

    // Below-BASE addresses wrap to huge offsets, so one unsigned compare bounds the window
    assign off     = bus.Addr - BASE;
    assign hit     = (off[1:0] == 2'b00) && (off <= OFF_CTRL);
    assign wr      = bus.MemWrite & hit;
    assign push    = wr && (off == OFF_DATA);
    assign ctrl_wr = wr && (off == OFF_CTRL);
    assign clr     = ctrl_wr & bus.WriteData[CTRL_CLR];
    assign ovfclr  = ctrl_wr & bus.WriteData[CTRL_OVFCLR];
    assign tx_vld  = en & ~empty;
    assign pop     = tx_vld & bus.TxReady;
    assign drop    = push & full & ~pop;
    assign cnt_ext = 32'(cnt);

    assign unused_bits = ^{bus.WriteData[31:8], cnt_ext[31:8]};

    fifo_sync #(.W(8), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .clr   (clr),
        .din   (bus.WriteData[7:0]),
        .dout  (head),
        .empty (empty),
        .full  (full),
        .count (cnt)
    );

    // Drain enable; only the en bit of CTRL is stored
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)         en <= 1'b0;
        else if (ctrl_wr) en <= bus.WriteData[CTRL_EN];
    end

    // Sticky overflow; a drop in the same cycle as ovfclr leaves it set
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)        ovf <= 1'b0;
        else if (drop)   ovf <= 1'b1;
        else if (ovfclr) ovf <= 1'b0;
    end

    // Register read mux; nothing here depends on TxReady
    always_comb begin
        rd = '0;
        if (hit) begin
            case (off)
                OFF_DATA:   if (!empty) rd[7:0] = head;
                OFF_STATUS: begin
                    rd[ST_EMPTY]          = empty;
                    rd[ST_FULL]           = full;
                    rd[ST_OVF]            = ovf;
                    rd[ST_CNT_LSB +: 8]   = cnt_ext[7:0];
                end
                OFF_CTRL:   rd[CTRL_EN] = en;
                default:    rd = '0;
            endcase
        end
    end

    assign bus.Hit     = hit;
    assign bus.RdData  = rd;
    assign bus.TxData  = head;
    assign bus.TxValid = tx_vld;
endmodule

// File: tb/tb_mmio_tx_port.sv
// Directed self-checking bench for mmio_tx_port (DEPTH=16, BASE=0x1000).
// Inputs change 1ns after the rising edge; outputs are sampled in the same settled window.
// Consumer backpressure is exercised with fixed and random TxReady patterns.
module tb_mmio_tx_port;
    localparam logic [31:0] BASE = 32'h0000_1000;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    mmio_tx_port_if bus ();

    mmio_tx_port #(.DEPTH(16), .BASE(BASE)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        bus.MemWrite  = 1'b1;
        bus.Addr      = a;
        bus.WriteData = d;
        tick();
        bus.MemWrite  = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        bus.Addr = a;
        #1;
        d = bus.RdData;
    endtask

    logic [31:0] v;
    logic [7:0]  q[$];
    logic [7:0]  exp_b;
    logic [7:0]  held;
    logic        stalled;
    logic        rdy;
    logic        psh;
    logic        vld_now;
    int          sent;
    int          got;
    int          iter;

    initial begin
        bus.MemWrite  = 1'b0;
        bus.Addr      = '0;
        bus.WriteData = '0;
        bus.TxReady   = 1'b0;

        // Reset state
        #1;
        chk("rst_txvalid", bus.TxValid, 1'b0);
        chk("rst_txdata", bus.TxData, 8'h00);
        tick();
        tick();
        rst = 1'b1;
        rd(BASE + 4, v); chk("rst_status", v, 32'h0000_0001);
        rd(BASE + 8, v); chk("rst_ctrl", v, 32'h0000_0000);
        rd(BASE + 0, v); chk("rst_data", v, 32'h0000_0000);

        // Streaming with the consumer always ready
        bus.TxReady = 1'b1;
        store(BASE + 8, 32'h1);
        store(BASE, 32'h41);
        chk("s1_vld0", bus.TxValid, 1'b1);
        chk("s1_dat0", bus.TxData, 8'h41);
        store(BASE, 32'h42);
        chk("s1_vld1", bus.TxValid, 1'b1);
        chk("s1_dat1", bus.TxData, 8'h42);
        store(BASE, 32'h43);
        chk("s1_dat2", bus.TxData, 8'h43);
        tick();
        chk("s1_idle", bus.TxValid, 1'b0);

        // Overflow with draining disabled
        store(BASE + 8, 32'h0);
        for (int i = 0; i < 17; i++) store(BASE, 32'(i));
        chk("s2_txvalid_dis", bus.TxValid, 1'b0);
        rd(BASE + 4, v); chk("s2_status_full_ovf", v, 32'h0000_1006);
        store(BASE + 8, 32'h1);
        for (int i = 0; i < 16; i++) begin
            chk("s2_drain_vld", bus.TxValid, 1'b1);
            chk("s2_drain_dat", bus.TxData, 32'(i));
            tick();
        end
        chk("s2_lost_0x10", bus.TxValid, 1'b0);
        rd(BASE + 4, v); chk("s2_status_ovf_kept", v, 32'h0000_0005);
        store(BASE + 8, 32'h5);
        rd(BASE + 4, v); chk("s2_ovfclr", v, 32'h0000_0001);
        rd(BASE + 8, v); chk("s2_ctrl_rd", v, 32'h0000_0001);

        // Full FIFO: push and pop in the same cycle
        bus.TxReady = 1'b0;
        for (int i = 0; i < 16; i++) store(BASE, 32'h20 + 32'(i));
        rd(BASE + 4, v); chk("s3_full", v, 32'h0000_1002);
        rd(BASE + 0, v); chk("s3_data_rd", v, 32'h0000_0020);
        bus.TxReady = 1'b1;
        store(BASE, 32'h55);
        rd(BASE + 4, v); chk("s3_full_no_ovf", v, 32'h0000_1002);
        for (int i = 0; i < 16; i++) begin
            v = (i < 15) ? 32'h21 + 32'(i) : 32'h55;
            chk("s3_order", bus.TxData, v);
            tick();
        end
        chk("s3_empty", bus.TxValid, 1'b0);

        // Clear while holding data
        bus.TxReady = 1'b0;
        for (int i = 0; i < 5; i++) store(BASE, 32'h60 + 32'(i));
        store(BASE, 32'h77);
        rd(BASE + 4, v); chk("s4_six", v, 32'h0000_0600);
        bus.TxReady = 1'b1;
        store(BASE + 8, 32'h3);
        rd(BASE + 4, v); chk("s4_cleared", v, 32'h0000_0001);
        chk("s4_no_77", bus.TxValid, 1'b0);
        rd(BASE + 8, v); chk("s4_ctrl_en_only", v, 32'h0000_0001);

        // Wrap-around with random stalls against a queue model
        sent = 0; got = 0; iter = 0; stalled = 1'b0; held = '0;
        while (got < 40 && iter < 2000) begin
            rdy = 1'($urandom_range(0, 1));
            psh = (sent < 40) && (q.size() < 16) && ($urandom_range(0, 2) != 0);
            bus.TxReady   = rdy;
            bus.MemWrite  = psh;
            bus.Addr      = BASE;
            bus.WriteData = 32'h80 + 32'(sent);
            #1;
            vld_now = bus.TxValid;
            chk("s5_valid", vld_now, (q.size() != 0));
            if (stalled) chk("s5_hold", bus.TxData, held);
            if (vld_now && rdy && q.size() != 0) begin
                exp_b = q.pop_front();
                chk("s5_order", bus.TxData, exp_b);
                got++;
            end
            if (psh) begin
                q.push_back(8'h80 + 8'(sent));
                sent++;
            end
            stalled = vld_now & ~rdy;
            held    = bus.TxData;
            tick();
            bus.MemWrite = 1'b0;
            iter++;
        end
        chk("s5_all_received", got, 40);

        // Misaligned and out-of-window accesses
        bus.TxReady   = 1'b1;
        bus.MemWrite  = 1'b1;
        bus.WriteData = 32'h99;
        bus.Addr      = BASE + 2;
        #1;
        chk("s5_hit_b2", bus.Hit, 1'b0);
        chk("s5_rd_b2", bus.RdData, 32'h0);
        tick();
        bus.Addr = BASE + 12;
        #1;
        chk("s5_hit_b12", bus.Hit, 1'b0);
        chk("s5_rd_b12", bus.RdData, 32'h0);
        tick();
        bus.MemWrite = 1'b0;
        rd(BASE + 4, v); chk("s5_no_push", v, 32'h0000_0001);
        bus.Addr = BASE + 8;
        #1;
        chk("s5_hit_ctrl", bus.Hit, 1'b1);

        // Reset in the middle of a drain
        bus.TxReady = 1'b0;
        for (int i = 0; i < 3; i++) store(BASE, 32'hA0 + 32'(i));
        bus.TxReady = 1'b1;
        #1;
        chk("s6_vld_before", bus.TxValid, 1'b1);
        chk("s6_dat_before", bus.TxData, 8'hA0);
        #1;
        rst = 1'b0;
        #1;
        chk("s6_vld_async", bus.TxValid, 1'b0);
        chk("s6_dat_async", bus.TxData, 8'h00);
        tick();
        rst = 1'b1;
        rd(BASE + 4, v); chk("s6_status", v, 32'h0000_0001);
        rd(BASE + 8, v); chk("s6_ctrl", v, 32'h0000_0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
